uart_tx_retry: RTL
==================

UART_TX_RETRY -- requirements
Module: uart_tx_retry

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload bits per frame (valid range 5..64).
REQ-002 SHALL have parameter PARITY_MODE, default 1, parity selection: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop-bit count (1 or 2).
REQ-004 SHALL have parameter CLKS_PER_BIT, default 1, clock cycles per serial bit (>=1).
REQ-005 SHALL have parameter MAX_RETRY, default 2, retransmissions allowed per accepted word (0..15).
REQ-006 SHALL have port CLK_Baudin  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port RstTx_n  input  1  reset, asynchronous assertion, active-low.
REQ-008 SHALL have port NewData  input  1  load request; sampled only in IDLE.
REQ-009 SHALL have port DataIn  input  DATA_W  word to send; captured when NewData is accepted.
REQ-010 SHALL have port flag  input  1  retransmission request from the receiver side.
REQ-011 SHALL have port TxSerial  output  1  serial line; idle high.
REQ-012 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port DoneTx  output  1  one-cycle pulse: frame completed with no retry pending.
REQ-014 SHALL have port Fail  output  1  one-cycle pulse: retry requested with retries exhausted.
REQ-015 SHALL have port RetryCnt  output  4  retransmissions performed for the current word.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-017 SHALL register all outputs; TxSerial SHALL be glitch-free.
REQ-018 IDLE with NewData=1 at an edge SHALL capture DataIn into a shadow register, clear RetryCnt, enter START; TxSerial SHALL be 0 from that edge.
REQ-019 NewData outside IDLE SHALL be ignored; the shadow register SHALL NOT change.
REQ-020 Each bit SHALL last exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads on every state change.
REQ-021 DATA SHALL send shadow bits LSB first; a bit index SHALL count 0..DATA_W-1, then the FSM moves to PARITY, or to STOP if PARITY_MODE=0.
REQ-022 The parity bit SHALL be the XOR of all DATA_W bits for even mode and its inverse for odd mode, and SHALL be computed from the shadow register.
REQ-023 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 Any cycle with flag=1 from START through the last STOP cycle inclusive SHALL set a sticky retry_req; flag in IDLE or GAP SHALL be ignored.
REQ-025 At the end of STOP, if retry_req=0, the FSM SHALL assert DoneTx for the next cycle and return to IDLE.
REQ-026 At the end of STOP, if retry_req=1 and RetryCnt<MAX_RETRY, the FSM SHALL increment RetryCnt, clear retry_req, and enter GAP.
REQ-027 At the end of STOP, if retry_req=1 and RetryCnt==MAX_RETRY, the FSM SHALL assert Fail for the next cycle, clear retry_req, and return to IDLE; DoneTx SHALL stay 0.
REQ-028 GAP SHALL drive 1 for one bit time, then enter START and resend the unchanged shadow word.
REQ-029 DoneTx and Fail SHALL never be high together.
REQ-030 Frame length SHALL be (1+DATA_W+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-031 RetryCnt SHALL hold its value after DoneTx or Fail until the next accepted NewData.

Reset
REQ-032 RstTx_n=0 SHALL immediately force IDLE, TxSerial=1, and Busy, DoneTx, Fail, RetryCnt, retry_req, counters and shadow to 0, including mid-frame.
REQ-033 After RstTx_n rises, the first NewData SHALL be accepted on the first rising edge.

Verification (defaults; NewData accepted at cycle 0)
REQ-034 Send 0xA5A5A5A5, flag=0 -> start bit cycle 0, data LSB-first cycles 1-32, parity 0 at cycle 33, stop 1 at cycle 34, DoneTx=1 at cycle 35 only, RetryCnt=0.
REQ-035 Send 0x12345678 with flag pulsed at cycle 33 -> parity bit 1, GAP at cycle 35, identical frame resent from cycle 36, DoneTx at cycle 71, RetryCnt=1.
REQ-036 Send 0xDEADBEEF with flag pulsed in every frame -> 3 frames (parity 0), Fail=1 once after the third stop bit, DoneTx never asserted, RetryCnt=2.
REQ-037 Pulse RstTx_n low at cycle 15 of a frame -> TxSerial=1 and Busy=0 asynchronously; a NewData of 0x00000001 right after release -> a clean frame with parity 1.
REQ-038 NewData=1 with DataIn=0xFFFFFFFF at cycle 10 of a frame -> ignored, original frame completes unchanged; with PARITY_MODE=2, STOP_BITS=2, CLKS_PER_BIT=4 -> each bit 4 cycles, frame 144 cycles.

Source files
------------

// File: rtl/uart_tx_retry.sv
// UART transmitter with optional parity, configurable stop bits and a bounded
// retransmit loop driven by the receiver-side flag input.
module uart_tx_retry #(
    parameter int DATA_W       = 32,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int MAX_RETRY    = 2
) (
    input  logic              CLK_Baudin,
    input  logic              RstTx_n,
    input  logic              NewData,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              flag,
    output logic              TxSerial,
    output logic              Busy,
    output logic              DoneTx,
    output logic              Fail,
    output logic [3:0]        RetryCnt
);

    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(STOP_LEN) + 1;
    localparam int IW       = $clog2(DATA_W);

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_RELOAD = TW'(STOP_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

    state_t            state_q, state_n;
    logic [TW-1:0]     timer_q, timer_n;
    logic [IW-1:0]     idx_q, idx_n;
    logic [DATA_W-1:0] shadow_q, shadow_n;
    logic              req_q, req_n;
    logic [3:0]        retry_n;
    logic              tx_n, busy_n, done_n, fail_n;
    logic              last_tick, parity_bit, req_now;

    assign last_tick  = (timer_q == '0);
    assign parity_bit = (PARITY_MODE == 2) ? ~(^shadow_q) : ^shadow_q;
    assign req_now    = req_q | flag;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q - TW'(1);
        idx_n    = idx_q;
        shadow_n = shadow_q;
        req_n    = req_q;
        retry_n  = RetryCnt;
        tx_n     = TxSerial;
        done_n   = 1'b0;
        fail_n   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_n = timer_q;
                if (NewData) begin
                    shadow_n = DataIn;
                    retry_n  = 4'd0;
                    req_n    = 1'b0;
                    timer_n  = BIT_RELOAD;
                    tx_n     = 1'b0;
                    state_n  = START;
                end
            end
            START: begin
                req_n = req_now;
                if (last_tick) begin
                    idx_n   = '0;
                    timer_n = BIT_RELOAD;
                    tx_n    = shadow_q[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                req_n = req_now;
                if (last_tick) begin
                    timer_n = BIT_RELOAD;
                    if (idx_q != LAST_IDX) begin
                        idx_n = idx_q + IW'(1);
                        tx_n  = shadow_q[idx_n];
                    end else if (PARITY_MODE != 0) begin
                        tx_n    = parity_bit;
                        state_n = PARITY;
                    end else begin
                        tx_n    = 1'b1;
                        timer_n = STOP_RELOAD;
                        state_n = STOP;
                    end
                end
            end
            PARITY: begin
                req_n = req_now;
                if (last_tick) begin
                    tx_n    = 1'b1;
                    timer_n = STOP_RELOAD;
                    state_n = STOP;
                end
            end
            STOP: begin
                req_n = req_now;
                if (last_tick) begin
                    req_n = 1'b0;
                    tx_n  = 1'b1;
                    if (!req_now) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else if (RetryCnt < 4'(MAX_RETRY)) begin
                        retry_n = RetryCnt + 4'd1;
                        timer_n = BIT_RELOAD;
                        state_n = GAP;
                    end else begin
                        fail_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                if (last_tick) begin
                    tx_n    = 1'b0;
                    timer_n = BIT_RELOAD;
                    state_n = START;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK_Baudin or negedge RstTx_n) begin
        if (!RstTx_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            req_q    <= 1'b0;
            RetryCnt <= 4'd0;
            TxSerial <= 1'b1;
            Busy     <= 1'b0;
            DoneTx   <= 1'b0;
            Fail     <= 1'b0;
        end else begin
            state_q  <= state_n;
            timer_q  <= timer_n;
            idx_q    <= idx_n;
            shadow_q <= shadow_n;
            req_q    <= req_n;
            RetryCnt <= retry_n;
            TxSerial <= tx_n;
            Busy     <= busy_n;
            DoneTx   <= done_n;
            Fail     <= fail_n;
        end
    end

endmodule
